// File: rtl/prefix_aligner_pkg.sv
// Shared constants for the prefix aligner: legacy prefix byte codes, segSEL bit
// positions, scan/present state encoding and the per-byte classification record.
package prefix_aligner_pkg;

  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;
  localparam logic [7:0] PFX_OPSZ  = 8'h66;
  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_FS    = 8'h64;
  localparam logic [7:0] PFX_GS    = 8'h65;

  localparam int SEG_ES = 0;
  localparam int SEG_CS = 1;
  localparam int SEG_SS = 2;
  localparam int SEG_DS = 3;
  localparam int SEG_FS = 4;
  localparam int SEG_GS = 5;

  typedef enum logic {
    SCAN    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  typedef struct packed {
    logic       is_pfx;
    logic       is_rep;
    logic       is_size;
    logic       is_seg;
    logic [5:0] seg_onehot;
  } pfx_class_t;

endpackage

// File: rtl/prefix_aligner_classify.sv
// Combinational legacy-prefix classifier: maps one byte to its prefix kind and,
// for segment overrides, the one-hot segment select.
module prefix_classify
  import prefix_aligner_pkg::*;
(
  input  logic [7:0]  i_byte,
  output pfx_class_t  o_cls
);

  always_comb begin
    o_cls = '0;
    case (i_byte)
      PFX_REPNE, PFX_REP: o_cls.is_rep  = 1'b1;
      PFX_OPSZ:           o_cls.is_size = 1'b1;
      PFX_ES: begin o_cls.is_seg = 1'b1; o_cls.seg_onehot[SEG_ES] = 1'b1; end
      PFX_CS: begin o_cls.is_seg = 1'b1; o_cls.seg_onehot[SEG_CS] = 1'b1; end
      PFX_SS: begin o_cls.is_seg = 1'b1; o_cls.seg_onehot[SEG_SS] = 1'b1; end
      PFX_DS: begin o_cls.is_seg = 1'b1; o_cls.seg_onehot[SEG_DS] = 1'b1; end
      PFX_FS: begin o_cls.is_seg = 1'b1; o_cls.seg_onehot[SEG_FS] = 1'b1; end
      PFX_GS: begin o_cls.is_seg = 1'b1; o_cls.seg_onehot[SEG_GS] = 1'b1; end
      default: ;
    endcase
    o_cls.is_pfx = o_cls.is_rep | o_cls.is_size | o_cls.is_seg;
  end

endmodule

// File: rtl/prefix_aligner.sv
// Fetch-to-decode byte aligner: shifting byte buffer, one-prefix-per-cycle strip,
// valid/ready presentation of B1..B3. Optional PREFIX_OVF_EN adds the pref_ovf flag.
module prefix_aligner
  import prefix_aligner_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int LINE_BYTES = 16,
  parameter int MAX_PREF   = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    flush,
  input  logic [8*LINE_BYTES-1:0] fetch_line,
  input  logic                    fetch_valid,
  output logic                    fetch_ready,
  output logic [7:0]              B1,
  output logic [7:0]              B2,
  output logic [7:0]              B3,
  output logic                    isREP,
  output logic                    isSIZE,
  output logic                    isSEG,
  output logic [5:0]              segSEL,
  output logic [3:0]              prefSize,
  output logic                    inst_valid,
  input  logic                    dec_ready,
  input  logic [3:0]              dec_len
`ifdef PREFIX_OVF_EN
  ,
  output logic                    pref_ovf
`endif
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LINE_BYTES);
  localparam logic [3:0] MAX_P = 4'(MAX_PREF);

  logic [7:0]    r_buf     [DEPTH];
  logic [7:0]    w_buf_nxt [DEPTH];
  logic [7:0]    w_line    [LINE_BYTES];
  logic [OW-1:0] r_occ;
  logic [OW-1:0] w_pop;
  logic [OW-1:0] w_occ_mid;
  logic [OW-1:0] w_dlen;
  state_t        r_state;
  logic          r_rep;
  logic          r_size;
  logic          r_seg;
  logic [5:0]    r_segsel;
  logic [3:0]    r_pref;
`ifdef PREFIX_OVF_EN
  logic          r_ovf;
`endif
  pfx_class_t    w_head;
  logic          w_scan_pfx;
  logic          w_scan_go;
  logic          w_xfer;
  logic          w_push;

  prefix_classify u_classify (
    .i_byte (r_buf[0]),
    .o_cls  (w_head)
  );

  assign fetch_ready = (r_occ <= OW'(DEPTH - LINE_BYTES));
  assign w_push      = fetch_valid && fetch_ready && !flush;
  assign w_scan_pfx  = (r_state == SCAN) && (r_occ != '0) && w_head.is_pfx && (r_pref < MAX_P);
  assign w_scan_go   = (r_state == SCAN) && !w_scan_pfx && (r_occ >= OW'(3));
  assign w_xfer      = (r_state == PRESENT) && dec_ready;
  assign w_dlen      = OW'(dec_len);

  always_comb begin
    w_pop = '0;
    if (w_scan_pfx)
      w_pop = OW'(1);
    else if (w_xfer)
      w_pop = (w_dlen < r_occ) ? w_dlen : r_occ;
  end

  assign w_occ_mid = r_occ - w_pop;

  always_comb begin
    for (int j = 0; j < LINE_BYTES; j++)
      w_line[j] = fetch_line[8*j +: 8];
  end

  // Pop shifts the head down first; an accepted line then lands at the post-pop tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_buf_nxt[i] = (i + int'(w_pop) < DEPTH) ? r_buf[AW'(i + int'(w_pop))] : 8'h00;
      if (w_push && (i >= int'(w_occ_mid)) && (i < int'(w_occ_mid) + LINE_BYTES))
        w_buf_nxt[i] = w_line[LW'(i - int'(w_occ_mid))];
    end
  end

  always_ff @(posedge clk) begin
    r_buf <= w_buf_nxt;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_occ    <= '0;
      r_state  <= SCAN;
      r_rep    <= 1'b0;
      r_size   <= 1'b0;
      r_seg    <= 1'b0;
      r_segsel <= '0;
      r_pref   <= '0;
`ifdef PREFIX_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else if (flush) begin
      r_occ    <= '0;
      r_state  <= SCAN;
      r_rep    <= 1'b0;
      r_size   <= 1'b0;
      r_seg    <= 1'b0;
      r_segsel <= '0;
      r_pref   <= '0;
`ifdef PREFIX_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_occ <= w_occ_mid + (w_push ? OW'(LINE_BYTES) : '0);
      case (r_state)
        SCAN: begin
          if (w_scan_pfx) begin
            r_pref <= r_pref + 4'd1;
            if (w_head.is_rep)  r_rep  <= 1'b1;
            if (w_head.is_size) r_size <= 1'b1;
            if (w_head.is_seg) begin
              r_seg    <= 1'b1;
              r_segsel <= w_head.seg_onehot;
            end
          end else if (w_scan_go) begin
            r_state <= PRESENT;
`ifdef PREFIX_OVF_EN
            r_ovf   <= w_head.is_pfx;
`endif
          end
        end
        PRESENT: begin
          if (dec_ready) begin
            r_state  <= SCAN;
            r_rep    <= 1'b0;
            r_size   <= 1'b0;
            r_seg    <= 1'b0;
            r_segsel <= '0;
            r_pref   <= '0;
`ifdef PREFIX_OVF_EN
            r_ovf    <= 1'b0;
`endif
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign inst_valid = (r_state == PRESENT);
  assign B1         = inst_valid ? r_buf[0] : 8'h00;
  assign B2         = inst_valid ? r_buf[1] : 8'h00;
  assign B3         = inst_valid ? r_buf[2] : 8'h00;
  assign isREP      = r_rep;
  assign isSIZE     = r_size;
  assign isSEG      = r_seg;
  assign segSEL     = r_segsel;
  assign prefSize   = r_pref;
`ifdef PREFIX_OVF_EN
  assign pref_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_prefix_aligner.sv
// Bench for prefix_aligner: directed scenarios plus a randomized run scored against
// a byte-queue model of prefix stripping. Honours PREFIX_OVF_EN when defined.
module tb_prefix_aligner;

  localparam int LB   = 16;
  localparam int MAXP = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          flush;
  logic [8*LB-1:0] fetch_line;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [7:0]    B1, B2, B3;
  logic          isREP, isSIZE, isSEG;
  logic [5:0]    segSEL;
  logic [3:0]    prefSize;
  logic          inst_valid;
  logic          dec_ready;
  logic [3:0]    dec_len;
`ifdef PREFIX_OVF_EN
  logic          pref_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prefix_aligner #(.DEPTH(32), .LINE_BYTES(LB), .MAX_PREF(MAXP)) dut (
    .clk(clk), .clr(clr), .flush(flush),
    .fetch_line(fetch_line), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .B1(B1), .B2(B2), .B3(B3),
    .isREP(isREP), .isSIZE(isSIZE), .isSEG(isSEG), .segSEL(segSEL), .prefSize(prefSize),
    .inst_valid(inst_valid), .dec_ready(dec_ready), .dec_len(dec_len)
`ifdef PREFIX_OVF_EN
    , .pref_ovf(pref_ovf)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit m_is_pfx(input logic [7:0] b);
    return b inside {8'hF2, 8'hF3, 8'h66, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
  endfunction

  function automatic logic [5:0] m_seg(input logic [7:0] b);
    case (b)
      8'h26: return 6'b000001;
      8'h2E: return 6'b000010;
      8'h36: return 6'b000100;
      8'h3E: return 6'b001000;
      8'h64: return 6'b010000;
      8'h65: return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic clear_dut();
    @(negedge clk);
    flush = 1'b1; fetch_valid = 1'b0; dec_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Advance negedge by negedge (dropping fetch_valid/dec_ready) until inst_valid or bound.
  task automatic wait_valid(input int bound, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      fetch_valid = 1'b0; dec_ready = 1'b0;
      lat++;
    end while (!inst_valid && lat < bound);
  endtask

  task automatic test_reset();
    clr = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    dec_len = 4'd1; fetch_line = '0;
    #13;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", fetch_ready); end
    checks++; if ({B1, B2, B3} !== 24'h0) begin errors++; $display("FAIL reset_bytes: got %h want 000000", {B1, B2, B3}); end
    checks++; if ({isREP, isSIZE, isSEG, segSEL, prefSize} !== 13'h0) begin
      errors++; $display("FAIL reset_prefix: got %h want 0", {isREP, isSIZE, isSEG, segSEL, prefSize}); end
    @(negedge clk); clr = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    clear_dut();
    fetch_line = '0; fetch_line[15:0] = 16'hD889; fetch_valid = 1'b1;
    wait_valid(10, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", lat); end
    checks++; if ({B1, B2, B3} !== 24'h89D800) begin errors++; $display("FAIL basic_bytes: got %h want 89d800", {B1, B2, B3}); end
    checks++; if ({isREP, isSIZE, isSEG, segSEL, prefSize} !== 13'h0) begin
      errors++; $display("FAIL basic_prefix: got %h want 0", {isREP, isSIZE, isSEG, segSEL, prefSize}); end
    // 16 -> 14 -> 3 (presents again) -> 2 (stalls)
    dec_ready = 1'b1; dec_len = 4'd2;
    wait_valid(10, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_second_present: got %0d want 2", lat); end
    dec_ready = 1'b1; dec_len = 4'd11;
    wait_valid(10, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_occ3_present: got %0d want 2", lat); end
    dec_ready = 1'b1; dec_len = 4'd1;
    wait_valid(5, lat);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_occ2_stall: got %b want 0", inst_valid); end
    // Occupancy 2: new line puts 11 22 33 at byte offsets 15..17 of the buffer
    fetch_line = '0; fetch_line[127:104] = 24'h332211; fetch_valid = 1'b1;
    wait_valid(10, lat);
    dec_ready = 1'b1; dec_len = 4'd15;
    wait_valid(10, lat);
    checks++; if ({B1, B2, B3} !== 24'h112233) begin errors++; $display("FAIL basic_tail_bytes: got %h want 112233", {B1, B2, B3}); end
    // dec_len 15 with only 3 bytes held must clamp to empty
    dec_ready = 1'b1; dec_len = 4'd15;
    @(negedge clk); dec_ready = 1'b0;
    fetch_line = '0; fetch_line[15:0] = 16'hD889; fetch_valid = 1'b1;
    wait_valid(10, lat);
    checks++; if (lat !== 2 || B1 !== 8'h89) begin
      errors++; $display("FAIL basic_clamp: got lat %0d B1 %h want lat 2 B1 89", lat, B1); end
  endtask

  task automatic test_prefixes();
    int lat;
    clear_dut();
    fetch_line = '0; fetch_line[31:0] = 32'hA5F32E66; fetch_valid = 1'b1;
    wait_valid(12, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL pfx_latency: got %0d want 5", lat); end
    checks++; if (B1 !== 8'hA5) begin errors++; $display("FAIL pfx_B1: got %h want a5", B1); end
    checks++; if ({isREP, isSIZE, isSEG} !== 3'b111) begin errors++; $display("FAIL pfx_flags: got %b want 111", {isREP, isSIZE, isSEG}); end
    checks++; if (segSEL !== 6'b000010) begin errors++; $display("FAIL pfx_segSEL: got %b want 000010", segSEL); end
    checks++; if (prefSize !== 4'd3) begin errors++; $display("FAIL pfx_size: got %0d want 3", prefSize); end
    dec_ready = 1'b1; dec_len = 4'd1;
    @(negedge clk); dec_ready = 1'b0;
    checks++; if ({isREP, isSIZE, isSEG, segSEL, prefSize} !== 13'h0) begin
      errors++; $display("FAIL pfx_cleared: got %h want 0", {isREP, isSIZE, isSEG, segSEL, prefSize}); end
  endtask

  task automatic test_seg_last_wins();
    int lat;
    clear_dut();
    fetch_line = '0; fetch_line[23:0] = 24'h8B6526; fetch_valid = 1'b1;
    wait_valid(12, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL seg_latency: got %0d want 4", lat); end
    checks++; if (segSEL !== 6'b100000) begin errors++; $display("FAIL seg_segSEL: got %b want 100000", segSEL); end
    checks++; if ({isREP, isSIZE, isSEG, prefSize} !== 7'b0010010) begin
      errors++; $display("FAIL seg_flags: got %b want 0010010", {isREP, isSIZE, isSEG, prefSize}); end
    checks++; if (B1 !== 8'h8B) begin errors++; $display("FAIL seg_B1: got %h want 8b", B1); end
  endtask

  task automatic test_backpressure();
    int lat;
    clear_dut();
    fetch_line = '0; fetch_line[15:0] = 16'hD889; fetch_valid = 1'b1; dec_ready = 1'b0;
    @(negedge clk);
    checks++; if (fetch_ready !== 1'b1 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL bp_first: got ready %b valid %b want 1 0", fetch_ready, inst_valid); end
    fetch_line = '0; fetch_line[23:0] = 24'h02018B;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      fetch_line = {LB{8'hFF}};
      checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d: got %b want 0", k, fetch_ready); end
      checks++; if (inst_valid !== 1'b1 || {B1, B2} !== 16'h89D8) begin
        errors++; $display("FAIL bp_hold_c%0d: got valid %b bytes %h want 1 89d8", k, inst_valid, {B1, B2}); end
    end
    dec_ready = 1'b1; dec_len = 4'd2;
    wait_valid(10, lat);
    checks++; if (fetch_ready !== 1'b0 || B1 !== 8'h00) begin
      errors++; $display("FAIL bp_occ30: got ready %b B1 %h want 0 00", fetch_ready, B1); end
    dec_ready = 1'b1; dec_len = 4'd14;
    wait_valid(10, lat);
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL bp_occ16_ready: got %b want 1", fetch_ready); end
    checks++; if ({B1, B2, B3} !== 24'h8B0102) begin errors++; $display("FAIL bp_second_line: got %h want 8b0102", {B1, B2, B3}); end
  endtask

  task automatic test_flush();
    int lat;
    clear_dut();
    fetch_line = '0; fetch_line[15:0] = 16'hD889; fetch_valid = 1'b1;
    wait_valid(10, lat);
    flush = 1'b1; fetch_valid = 1'b1; fetch_line = {LB{8'hA5}};
    @(negedge clk);
    flush = 1'b0; fetch_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      errors++; $display("FAIL flush_next: got valid %b ready %b want 0 1", inst_valid, fetch_ready); end
    repeat (4) @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_line_dropped: got %b want 0", inst_valid); end
  endtask

  task automatic test_ovf();
    int lat;
    clear_dut();
    fetch_line = '0; fetch_line[47:0] = 48'h906666666666; fetch_valid = 1'b1;
    wait_valid(14, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL ovf_latency: got %0d want 6", lat); end
    checks++; if ({B1, B2} !== 16'h6690 || prefSize !== 4'd4) begin
      errors++; $display("FAIL ovf_present: got bytes %h size %0d want 6690 4", {B1, B2}, prefSize); end
`ifdef PREFIX_OVF_EN
    checks++; if (pref_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", pref_ovf); end
    dec_ready = 1'b1; dec_len = 4'd2;
    @(negedge clk); dec_ready = 1'b0;
    checks++; if (pref_ovf !== 1'b0) begin errors++; $display("FAIL ovf_flag_clear: got %b want 0", pref_ovf); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] pt [9] = '{8'hF2, 8'hF3, 8'h66, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    logic [7:0] b;
    logic [7:0] e_b1, e_b2, e_b3;
    logic [5:0] e_sel;
    logic       e_rep, e_size, e_seg, e_ovf, push;
    int         e_np, n, hs;
    bit         need_new;
    need_new = 1'b1; hs = 0;
    e_b1 = 0; e_b2 = 0; e_b3 = 0; e_sel = 0; e_rep = 0; e_size = 0; e_seg = 0; e_ovf = 0; e_np = 0;
    clear_dut();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (inst_valid) begin
        if (need_new) begin
          e_np = 0; e_rep = 0; e_size = 0; e_seg = 0; e_sel = 0;
          while (e_np < MAXP && q.size() > 0 && m_is_pfx(q[0])) begin
            b = q.pop_front();
            if (b == 8'hF2 || b == 8'hF3) e_rep = 1'b1;
            if (b == 8'h66) e_size = 1'b1;
            if (m_seg(b) != 6'b0) begin e_seg = 1'b1; e_sel = m_seg(b); end
            e_np++;
          end
          e_ovf = (q.size() > 0) && m_is_pfx(q[0]);
          checks++;
          if (q.size() < 3) begin
            errors++; $display("FAIL rnd_short_present: got %0d bytes held want >=3", q.size());
            e_b1 = 8'hxx; e_b2 = 8'hxx; e_b3 = 8'hxx;
          end else begin
            e_b1 = q[0]; e_b2 = q[1]; e_b3 = q[2];
          end
          need_new = 1'b0;
        end
        checks++; if ({B1, B2, B3} !== {e_b1, e_b2, e_b3}) begin
          errors++; $display("FAIL rnd_bytes c%0d: got %h want %h", cyc, {B1, B2, B3}, {e_b1, e_b2, e_b3}); end
        checks++; if ({isREP, isSIZE, isSEG, segSEL} !== {e_rep, e_size, e_seg, e_sel}) begin
          errors++; $display("FAIL rnd_flags c%0d: got %b want %b", cyc, {isREP, isSIZE, isSEG, segSEL}, {e_rep, e_size, e_seg, e_sel}); end
        checks++; if (prefSize !== 4'(e_np)) begin
          errors++; $display("FAIL rnd_prefSize c%0d: got %0d want %0d", cyc, prefSize, e_np); end
`ifdef PREFIX_OVF_EN
        checks++; if (pref_ovf !== e_ovf) begin
          errors++; $display("FAIL rnd_ovf c%0d: got %b want %b", cyc, pref_ovf, e_ovf); end
`endif
      end
      dec_ready = ($urandom_range(0, 3) != 0);
      dec_len   = 4'($urandom_range(1, 8));
      push      = fetch_ready && ($urandom_range(0, 1) == 1);
      for (int j = 0; j < LB; j++) begin
        if ($urandom_range(0, 99) < 35) b = pt[$urandom_range(0, 8)];
        else b = 8'($urandom_range(0, 255));
        fetch_line[8*j +: 8] = b;
      end
      fetch_valid = push;
      if (inst_valid && dec_ready) begin
        n = (int'(dec_len) < q.size()) ? int'(dec_len) : q.size();
        for (int k = 0; k < n; k++) void'(q.pop_front());
        need_new = 1'b1; hs++;
      end
      if (push)
        for (int j = 0; j < LB; j++) q.push_back(fetch_line[8*j +: 8]);
    end
    fetch_valid = 1'b0; dec_ready = 1'b0;
    checks++; if (hs < 50) begin errors++; $display("FAIL rnd_progress: got %0d handshakes want >=50", hs); end
  endtask

  task automatic test_async_reset();
    int lat;
    clear_dut();
    fetch_line = '0; fetch_line[15:0] = 16'h8966; fetch_valid = 1'b1;
    wait_valid(10, lat);
    #2 clr = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || isSIZE !== 1'b0 || prefSize !== 4'd0 || fetch_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got valid %b size %b pref %0d ready %b want 0 0 0 1",
                         inst_valid, isSIZE, prefSize, fetch_ready); end
    @(negedge clk); clr = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefixes();
    test_seg_last_wins();
    test_backpressure();
    test_flush();
    test_ovf();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefix_aligner.md
Name: prefix_aligner

Overview:
- Front-end byte aligner between the fetch line buffer and the control-store decode stage.
- Buffers raw fetch bytes and strips legacy prefixes (REP, operand-size, segment override) one per cycle.
- Presents B1/B2/B3 plus prefix summary (isREP, isSIZE, isSEG, prefSize, segSEL) to the decoder under a valid/ready handshake.
- Pops the consumed instruction length reported back by the decoder.

Parameters:
- DEPTH, 32, byte buffer capacity; must be ≥ 2×LINE_BYTES.
- LINE_BYTES, 16, bytes per fetch line.
- MAX_PREF, 4, maximum prefixes absorbed per instruction.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous redirect: empty the buffer and clear prefix state.
- fetch_line  input  8*LINE_BYTES  raw bytes; byte 0 in [7:0] is the lowest address.
- fetch_valid  input  1  fetch_line is valid.
- fetch_ready  output  1  room for a full line.
- B1, B2, B3  output  8 each  first three non-prefix bytes at the head.
- isREP  output  1  F2 or F3 seen.
- isSIZE  output  1  66 seen.
- isSEG  output  1  segment override seen.
- segSEL  output  6  one-hot ES/CS/SS/DS/FS/GS, bits 0..5.
- prefSize  output  4  number of prefix bytes stripped, binary 0..MAX_PREF.
- inst_valid  output  1  outputs above are valid.
- dec_ready  input  1  decoder accepts this cycle.
- dec_len  input  4  non-prefix bytes consumed, 1..15.

Behaviour:
- Reset (clr=0), asynchronous: occupancy=0; state=SCAN; all prefix registers 0; inst_valid=0; fetch_ready=1; B1..B3=0.
- Push: when fetch_valid && fetch_ready, append LINE_BYTES at the tail at the clock edge.
  - fetch_ready = (DEPTH − occupancy ≥ LINE_BYTES), computed from registered occupancy only. The same-cycle pop is not credited.
- State SCAN, with occupancy ≥ 1 and head byte a prefix (F2, F3, 66, 26, 2E, 36, 3E, 64, 65) and prefSize < MAX_PREF:
  - Pop 1 byte and increment prefSize.
  - Set the matching flag.
  - A segment prefix overwrites segSEL with its one-hot code; the last override wins.
  - Duplicate prefixes are legal.
- State SCAN, head byte not a prefix (or prefSize == MAX_PREF), and occupancy ≥ 3: go to PRESENT. Otherwise stay in SCAN; an empty or short buffer stalls.
- State PRESENT:
  - inst_valid=1.
  - B1..B3 are combinational from buffer head bytes 0..2.
  - Prefix outputs are held from registers.
- Handshake: the transfer happens on inst_valid && dec_ready.
  - Pop min(dec_len, occupancy) bytes.
  - Clear all prefix registers and prefSize.
  - Return to SCAN.
  - If dec_ready=0, all outputs stay stable.
- Ordering within one edge: push and pop in the same cycle apply pop first, then append at the new tail; occupancy += LINE_BYTES − popped.
- Latency: a prefix-free instruction at the head of an empty buffer gives inst_valid 2 cycles after the push edge (SCAN evaluation cycle, then PRESENT). Each prefix adds 1 cycle.
- Flush has priority over push, pop and scan. Next cycle: occupancy=0, state=SCAN, prefixes cleared, inst_valid=0. A push coincident with flush is dropped.
- Reset or flush during PRESENT discards the instruction. There is no partial retention.
- Buffer is a shifting byte array; the head is always index 0. There is no wrap pointer.

Optional Feature:
- PREFIX_OVF_EN defined:
  - Adds output pref_ovf (1 bit).
  - If a prefix byte is at the head while prefSize == MAX_PREF, go to PRESENT with pref_ovf=1.
  - pref_ovf is cleared on the handshake, flush or reset.
- Undefined: no port; such a byte is presented silently as B1.

Decomposition:
- Shared package holds:
  - prefix byte constants: PFX_REPNE=F2, PFX_REP=F3, PFX_OPSZ=66, PFX_ES=26, PFX_CS=2E, PFX_SS=36, PFX_DS=3E, PFX_FS=64, PFX_GS=65;
  - segSEL bit indices SEG_ES=0..SEG_GS=5;
  - state encoding SCAN/PRESENT.
- Sub-module prefix_classify: combinational, byte → {is_pfx, is_rep, is_size, is_seg, seg_onehot[5:0]}.

Test Plan:
- Push line 89 D8 00..00; decoder ready with dec_len=2 → inst_valid 2 cycles after push; B1=89, B2=D8; prefSize=0; all flags 0; occupancy 16→14.
- Push 66 2E F3 A5 00..00 → 3 scan cycles, then B1=A5; isSIZE=1, isSEG=1, segSEL=000010, isREP=1, prefSize=3.
- Push 26 65 8B 00 00… → segSEL=100000 (GS, last wins); prefSize=2.
- Hold dec_ready=0 for 5 cycles while fetch_valid stays high → outputs stable; fetch_ready drops once occupancy > 16; no overflow.
- Assert flush in PRESENT alongside fetch_valid → next cycle inst_valid=0, occupancy=0, the line is dropped.
- With PREFIX_OVF_EN, push 66 66 66 66 66 90 → PRESENT with B1=66, prefSize=4, pref_ovf=1; without the macro, same B1 and prefSize and no flag.
